// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, FSM encoding, GF(2^8) helpers, S-boxes, rcon, byte-order helpers.
// Used by both the encoder and the inverse core.
package aes_pkg;

   localparam int unsigned AES_NR = 10;
   localparam int unsigned AES_W  = 128;

   // Element 0 maps to bits [127:120], so a plain cast matches the FIPS-197 byte order.
   typedef logic [0:15][7:0] aes_state_t;

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} aes_fsm_t;

   function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
      return 4 * c + r;
   endfunction

   function automatic aes_state_t to_state(input logic [127:0] v);
      return aes_state_t'(v);
   endfunction

   function automatic logic [127:0] from_state(input aes_state_t s);
      return 128'(s);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int unsigned k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: rk[i-1], rcon[i] -> rk[i]. Purely combinational.
module aes_key_expand_step
   import aes_pkg::*;
(
   input  logic [127:0] i_rk_prev,
   input  logic [7:0]   i_rcon,
   output logic [127:0] o_rk_next
);

   logic [31:0] w_w0, w_w1, w_w2, w_w3, w_temp;
   logic [31:0] w_n0, w_n1, w_n2, w_n3;

   assign w_w0 = i_rk_prev[127:96];
   assign w_w1 = i_rk_prev[95:64];
   assign w_w2 = i_rk_prev[63:32];
   assign w_w3 = i_rk_prev[31:0];

   // SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}
   assign w_temp = {sbox(w_w3[23:16]) ^ i_rcon, sbox(w_w3[15:8]),
                    sbox(w_w3[7:0]), sbox(w_w3[31:24])};

   assign w_n0 = w_w0 ^ w_temp;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;

   assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher: 10-cycle forward key expansion, then 10 inverse rounds, one per cycle.
// Optional AES_INV_KEY_CACHE_EN: reuse the stored schedule when the same key arrives again.
module aes_inv_core
   import aes_pkg::*;
#(
   parameter int unsigned NR    = AES_NR,
   parameter int unsigned KEY_W = AES_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KEY_W-1:0] cipher_text,
   input  logic [KEY_W-1:0] cipher_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] plain_text,
   output logic             busy
);

   if (NR != 10 || KEY_W != 128) begin : g_param_check
      $error("aes_inv_core supports only NR=10 and KEY_W=128");
   end

   aes_fsm_t     r_fsm, w_fsm_next;
   logic [3:0]   r_rnd;
   logic [127:0] r_rk [0:10];
   aes_state_t   r_state;
   logic [127:0] r_pt;
   logic         r_out_valid;
   logic         w_accept, w_hit;
   logic [127:0] w_kprev, w_rk_next;
   aes_state_t   w_isr, w_isb, w_ark, w_imc, w_round;

   assign in_ready   = (r_fsm == IDLE) && !rst;
   assign busy       = (r_fsm != IDLE);
   assign out_valid  = r_out_valid;
   assign plain_text = r_pt;
   assign w_accept   = in_valid && in_ready;

`ifdef AES_INV_KEY_CACHE_EN
   logic r_cache_valid;
   assign w_hit = r_cache_valid && (cipher_key == r_rk[0]);
`else
   assign w_hit = 1'b0;
`endif

   assign w_kprev = (r_rnd == 4'd0) ? r_rk[0] : r_rk[r_rnd - 4'd1];

   aes_key_expand_step u_kstep (
      .i_rk_prev (w_kprev),
      .i_rcon    (rcon(r_rnd)),
      .o_rk_next (w_rk_next)
   );

   always_comb begin
      w_isr = '0;
      w_isb = '0;
      w_imc = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            w_isr[byte_idx(r, c)] = r_state[byte_idx(r, (c + 4 - r) % 4)];
      for (int unsigned i = 0; i < 16; i++)
         w_isb[i] = inv_sbox(w_isr[i]);
      w_ark = w_isb ^ r_rk[r_rnd];
      for (int unsigned c = 0; c < 4; c++) begin
         w_imc[byte_idx(0, c)] = gmul(w_ark[byte_idx(0, c)], 8'h0e) ^ gmul(w_ark[byte_idx(1, c)], 8'h0b)
                               ^ gmul(w_ark[byte_idx(2, c)], 8'h0d) ^ gmul(w_ark[byte_idx(3, c)], 8'h09);
         w_imc[byte_idx(1, c)] = gmul(w_ark[byte_idx(0, c)], 8'h09) ^ gmul(w_ark[byte_idx(1, c)], 8'h0e)
                               ^ gmul(w_ark[byte_idx(2, c)], 8'h0b) ^ gmul(w_ark[byte_idx(3, c)], 8'h0d);
         w_imc[byte_idx(2, c)] = gmul(w_ark[byte_idx(0, c)], 8'h0d) ^ gmul(w_ark[byte_idx(1, c)], 8'h09)
                               ^ gmul(w_ark[byte_idx(2, c)], 8'h0e) ^ gmul(w_ark[byte_idx(3, c)], 8'h0b);
         w_imc[byte_idx(3, c)] = gmul(w_ark[byte_idx(0, c)], 8'h0b) ^ gmul(w_ark[byte_idx(1, c)], 8'h0d)
                               ^ gmul(w_ark[byte_idx(2, c)], 8'h09) ^ gmul(w_ark[byte_idx(3, c)], 8'h0e);
      end
      w_round = (r_rnd == 4'd0) ? w_ark : w_imc;
   end

   always_ff @(posedge clk) begin
      if (rst) r_fsm <= IDLE;
      else     r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    if (w_accept) w_fsm_next = w_hit ? ROUND : KEXP;
         KEXP:    if (r_rnd == 4'd10) w_fsm_next = ROUND;
         ROUND:   if (r_rnd == 4'd0) w_fsm_next = DONE;
         DONE:    if (out_ready) w_fsm_next = IDLE;
         default: w_fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rnd       <= '0;
         r_out_valid <= 1'b0;
         r_pt        <= '0;
`ifdef AES_INV_KEY_CACHE_EN
         r_cache_valid <= 1'b0;
`endif
      end else begin
         case (r_fsm)
            IDLE: if (w_accept) begin
               if (w_hit) begin
                  r_state <= to_state(cipher_text ^ r_rk[10]);
                  r_rnd   <= 4'd9;
               end else begin
                  r_state <= to_state(cipher_text);
                  r_rk[0] <= cipher_key;
                  r_rnd   <= 4'd1;
`ifdef AES_INV_KEY_CACHE_EN
                  r_cache_valid <= 1'b0;
`endif
               end
            end
            KEXP: begin
               r_rk[r_rnd] <= w_rk_next;
               // rk10 is still being written this edge, so whiten with the step output directly.
               if (r_rnd == 4'd10) begin
                  r_state <= r_state ^ w_rk_next;
                  r_rnd   <= 4'd9;
`ifdef AES_INV_KEY_CACHE_EN
                  r_cache_valid <= 1'b1;
`endif
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            ROUND: begin
               r_state <= w_round;
               if (r_rnd == 4'd0) begin
                  r_pt        <= from_state(w_round);
                  r_out_valid <= 1'b1;
               end else begin
                  r_rnd <= r_rnd - 4'd1;
               end
            end
            DONE: if (out_ready) r_out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_core.sv
// Self-checking bench for aes_inv_core: FIPS-197 vectors, handshake/latency, reset abort, random ops vs a table-driven model.
module tb_aes_inv_core;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic         in_ready, out_valid, busy;
   logic [127:0] cipher_text, cipher_key, plain_text;

   int checks = 0;
   int errors = 0;

`ifdef AES_INV_KEY_CACHE_EN
   localparam int HIT_LAT = 10;
`else
   localparam int HIT_LAT = 20;
`endif

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clk = ~clk;

   aes_inv_core #(.NR(10), .KEY_W(128)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cipher_text (cipher_text),
      .cipher_key  (cipher_key),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .plain_text  (plain_text),
      .busy        (busy)
   );

   // ---------------- reference model ----------------
   logic [7:0] m_sbox  [256];
   logic [7:0] m_isbox [256];

   function automatic logic [7:0] m_mul(input int a, input int b);
      int p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if ((y & 1) != 0) p = p ^ x;
         x = x << 1;
         if ((x & 'h100) != 0) x = x ^ 'h11B;
         y = y >> 1;
      end
      return p[7:0];
   endfunction

   task automatic m_init();
      logic [7:0] inv, s, cst;
      cst = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (m_mul(a, b) == 8'h01) inv = b[7:0];
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         m_sbox[a]  = s;
         m_isbox[s] = a[7:0];
      end
   endtask

   function automatic logic [127:0] m_decrypt(input logic [127:0] key, input logic [127:0] ct);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [7:0]   coef [4];
      logic [127:0] res;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {m_sbox[tmp[23:16]] ^ rc, m_sbox[tmp[15:8]], m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]};
            rc  = m_mul(rc, 2);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) begin
         tmp  = w[40 + i/4];
         s[i] = ct[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
      end
      for (int rd = 9; rd >= 0; rd--) begin
         for (int i = 0; i < 16; i++)
            t[i] = m_isbox[s[(i%4) + 4*(((i/4) + 4 - (i%4)) % 4)]];
         for (int i = 0; i < 16; i++) begin
            tmp  = w[4*rd + i/4];
            s[i] = t[i] ^ tmp[31-8*(i%4) -: 8];
         end
         if (rd > 0) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  t[4*c+r] = 8'h00;
                  for (int k = 0; k < 4; k++)
                     t[4*c+r] = t[4*c+r] ^ m_mul(s[4*c+k], coef[(k - r + 4) % 4]);
               end
            s = t;
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input string tag, input logic [127:0] key, input logic [127:0] ct);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
      cipher_key  = key;
      cipher_text = ct;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] exp_pt, input int exp_lat, input bit garbage, input int hold);
      int n;
      start_op(tag, key, ct);
      chk({tag, "_busy"}, 128'(busy), 128'd1);
      n = 0;
      while (!out_valid && n < 40) begin
         if (garbage) begin
            in_valid    = 1'($urandom % 2);
            cipher_key  = {$urandom, $urandom, $urandom, $urandom};
            cipher_text = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
      chk({tag, "_pt"}, plain_text, exp_pt);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_pt"}, plain_text, exp_pt);
         chk({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
         chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk({tag, "_rel_in_ready"}, 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, 128'(out_valid), 128'd0);
      chk({tag, "_post_in_ready"}, 128'(in_ready), 128'd1);
      chk({tag, "_post_busy"}, 128'(busy), 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] rk, rc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cipher_text = '0; cipher_key = '0;
      m_init();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_pt", plain_text, 128'd0);
      chk("rst_in_ready_held", 128'(in_ready), 128'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready_rel", 128'(in_ready), 128'd1);

      run_op("c1", K1, C1, P1, 20, 1'b0, 0);
      run_op("c1_repeat", K1, C1, P1, HIT_LAT, 1'b0, 0);
      run_op("fipsB_hold", K2, C2, P2, 20, 1'b0, 5);
      run_op("alt_c1", K1, C1, P1, 20, 1'b0, 0);
      run_op("alt_b", K2, C2, P2, 20, 1'b0, 0);
      run_op("alt_c1b", K1, C1, P1, 20, 1'b0, 0);

      // Abort in ROUND with rnd==5 (14 edges after a cache-miss accept).
      start_op("abort", {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      repeat (14) begin
         @(posedge clk); #1;
      end
      chk("abort_busy_pre", 128'(busy), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_out_valid", 128'(out_valid), 128'd0);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_pt", plain_text, 128'd0);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      run_op("after_abort_c1", K1, C1, P1, 20, 1'b0, 0);

      run_op("garbage_b", K2, C2, P2, 20, 1'b1, 0);

      for (int i = 0; i < 6; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rc = {$urandom, $urandom, $urandom, $urandom};
         run_op($sformatf("rand%0d", i), rk, rc, m_decrypt(rk, rc), 20, 1'b0, 0);
         rc = {$urandom, $urandom, $urandom, $urandom};
         run_op($sformatf("rand%0d_same_key", i), rk, rc, m_decrypt(rk, rc), HIT_LAT, 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
